// File: rtl/wam_game_core.sv
`default_nettype none
// ============================================================================
// Module   : wam_game_core
// Purpose  : Whack-a-mole game engine. Tracks the lit mole, scores hits,
//            counts misses and lives, runs the timed-mode countdown and
//            sequences IDLE -> PLAY -> OVER for the four game modes.
// Ports    : clk, reset (sync, active-high)
//            start/mode/extended/level_in  - game start and configuration
//            spawn_valid/spawn_pos/expire   - light controller events
//            key_valid/key_pos              - keypad events
//            state/score/spawned/lives_left/time_left/level_out - display
//            active/active_pos              - currently lit mole
//            hit_pulse/miss_pulse/clear_light - one-cycle event pulses
//            game_over                      - high while in OVER
// Revision : 1.0 - initial release
// ============================================================================
module wam_game_core #(
    parameter int NUM_LIGHTS    = 9,
    parameter int POS_W         = 4,
    parameter int SCORE_MAX     = 99,
    parameter int NORMAL_MAX    = 25,
    parameter int EXT_MAX       = 50,
    parameter int LIVES         = 3,
    parameter int GAME_SECONDS  = 60,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int LEVEL_UP      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             extended,
    input  logic [1:0]       level_in,
    input  logic             spawn_valid,
    input  logic [POS_W-1:0] spawn_pos,
    input  logic             expire,
    input  logic             key_valid,
    input  logic [POS_W-1:0] key_pos,
    output logic [1:0]       state,
    output logic [6:0]       score,
    output logic [6:0]       spawned,
    output logic [1:0]       lives_left,
    output logic [5:0]       time_left,
    output logic [1:0]       level_out,
    output logic             active,
    output logic [POS_W-1:0] active_pos,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             clear_light,
    output logic             game_over
);

    localparam int c_presc_w = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int c_lvl_w   = (LEVEL_UP > 1) ? $clog2(LEVEL_UP) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICKS_PER_SEC - 1);
    localparam logic [c_lvl_w-1:0]   c_lvl_last   = c_lvl_w'(LEVEL_UP - 1);
    localparam logic [POS_W:0]       c_num_lights = (POS_W + 1)'(NUM_LIGHTS);
    localparam logic [6:0]           c_score_max  = 7'(SCORE_MAX);
    localparam logic [6:0]           c_normal_max = 7'(NORMAL_MAX);
    localparam logic [6:0]           c_ext_max    = 7'(EXT_MAX);
    localparam logic [1:0]           c_lives      = 2'(LIVES);
    localparam logic [5:0]           c_game_sec   = 6'(GAME_SECONDS);

    localparam logic [1:0] c_mode_timed = 2'd1;
    localparam logic [1:0] c_mode_death = 2'd2;
    localparam logic [1:0] c_mode_cont  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [1:0]             r_mode, w_mode_nxt;
    logic                   r_ext, w_ext_nxt;
    logic [6:0]             r_score, w_score_nxt;
    logic [6:0]             r_spawned, w_spawned_nxt;
    logic [1:0]             r_lives, w_lives_nxt;
    logic [5:0]             r_time, w_time_nxt;
    logic [1:0]             r_level, w_level_nxt;
    logic                   r_active, w_active_nxt;
    logic [POS_W-1:0]       r_pos, w_pos_nxt;
    logic                   r_hit, w_hit_nxt;
    logic                   r_miss, w_miss_nxt;
    logic [c_presc_w-1:0]   r_presc, w_presc_nxt;
    // Hits since the last level step; avoids a modulo on the score.
    logic [c_lvl_w-1:0]     r_lvl_cnt, w_lvl_cnt_nxt;

    logic       w_hit, w_spawn_ok, w_miss, w_end;
    logic [6:0] w_max;

    assign w_max = r_ext ? c_ext_max : c_normal_max;

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_ext_nxt     = r_ext;
        w_score_nxt   = r_score;
        w_spawned_nxt = r_spawned;
        w_lives_nxt   = r_lives;
        w_time_nxt    = r_time;
        w_level_nxt   = r_level;
        w_active_nxt  = r_active;
        w_pos_nxt     = r_pos;
        w_hit_nxt     = 1'b0;
        w_miss_nxt    = 1'b0;
        w_presc_nxt   = r_presc;
        w_lvl_cnt_nxt = r_lvl_cnt;
        w_hit         = 1'b0;
        w_spawn_ok    = 1'b0;
        w_miss        = 1'b0;
        w_end         = 1'b0;

        if (start) begin
            w_state_nxt   = S_PLAY;
            w_mode_nxt    = mode;
            w_ext_nxt     = extended;
            w_score_nxt   = '0;
            w_spawned_nxt = '0;
            w_lives_nxt   = c_lives;
            w_time_nxt    = c_game_sec;
            w_level_nxt   = (mode == c_mode_cont) ? 2'd0 : level_in;
            w_active_nxt  = 1'b0;
            w_presc_nxt   = '0;
            w_lvl_cnt_nxt = '0;
        end else if (r_state == S_PLAY) begin
            w_hit      = key_valid & r_active & (key_pos == r_pos);
            w_spawn_ok = spawn_valid & ({1'b0, spawn_pos} < c_num_lights) & (r_spawned < w_max);
            // All miss sources collapse into a single miss (and a single life).
            w_miss     = (expire & r_active & ~w_hit)
                       | ((r_mode == c_mode_death) & key_valid & ~w_hit)
                       | (w_spawn_ok & r_active & ~w_hit);
            w_hit_nxt  = w_hit;
            w_miss_nxt = w_miss;

            if (w_hit && (r_score < c_score_max)) begin
                w_score_nxt = r_score + 7'd1;
                if (r_mode == c_mode_cont) begin
                    if (r_lvl_cnt == c_lvl_last) begin
                        w_lvl_cnt_nxt = '0;
                        if (r_level != 2'd3) begin
                            w_level_nxt = r_level + 2'd1;
                        end
                    end else begin
                        w_lvl_cnt_nxt = r_lvl_cnt + c_lvl_w'(1);
                    end
                end
            end

            // A fresh spawn always becomes the active mole, even on a hit.
            if (w_spawn_ok) begin
                w_active_nxt  = 1'b1;
                w_pos_nxt     = spawn_pos;
                w_spawned_nxt = r_spawned + 7'd1;
            end else if (w_hit || w_miss) begin
                w_active_nxt = 1'b0;
            end

            if (w_miss && (r_mode == c_mode_death) && (r_lives != 2'd0)) begin
                w_lives_nxt = r_lives - 2'd1;
            end

            if (r_mode == c_mode_timed) begin
                if (r_presc == c_presc_last) begin
                    w_presc_nxt = '0;
                    if (r_time != 6'd0) begin
                        w_time_nxt = r_time - 6'd1;
                    end
                end else begin
                    w_presc_nxt = r_presc + c_presc_w'(1);
                end
            end

            // End test uses this cycle's updated values so OVER appears
            // together with the event that ends the game.
            case (r_mode)
                c_mode_timed: w_end = (w_time_nxt == 6'd0);
                c_mode_death: w_end = (w_lives_nxt == 2'd0) ||
                                      ((w_spawned_nxt == w_max) && !w_active_nxt);
                default:      w_end = (w_spawned_nxt == w_max) && !w_active_nxt;
            endcase

            if (w_end) begin
                w_state_nxt  = S_OVER;
                w_active_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= 2'd0;
            r_ext     <= 1'b0;
            r_score   <= '0;
            r_spawned <= '0;
            r_lives   <= c_lives;
            r_time    <= c_game_sec;
            r_level   <= 2'd0;
            r_active  <= 1'b0;
            r_pos     <= '0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_presc   <= '0;
            r_lvl_cnt <= '0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_ext     <= w_ext_nxt;
            r_score   <= w_score_nxt;
            r_spawned <= w_spawned_nxt;
            r_lives   <= w_lives_nxt;
            r_time    <= w_time_nxt;
            r_level   <= w_level_nxt;
            r_active  <= w_active_nxt;
            r_pos     <= w_pos_nxt;
            r_hit     <= w_hit_nxt;
            r_miss    <= w_miss_nxt;
            r_presc   <= w_presc_nxt;
            r_lvl_cnt <= w_lvl_cnt_nxt;
        end
    end

    assign state       = r_state;
    assign score       = r_score;
    assign spawned     = r_spawned;
    assign lives_left  = r_lives;
    assign time_left   = r_time;
    assign level_out   = r_level;
    assign active      = r_active;
    assign active_pos  = r_pos;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign clear_light = r_hit;
    assign game_over   = (r_state == S_OVER);

endmodule
`default_nettype wire
